// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = A - B - borrow_in over WIDTH cycles,
// with a start/busy/done handshake and registered result outputs.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] sa_q,     sa_d;
    logic [WIDTH-1:0] sb_q,     sb_d;
    logic [WIDTH-1:0] res_q,    res_d;
    logic             br_q,     br_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic             borrow_q, borrow_d;

    logic             d_bit_s;
    logic             br_next_s;
    logic [WIDTH-1:0] res_next_s;

    // Full-subtractor bit slice on the current LSBs and the running borrow.
    always_comb begin
        d_bit_s    = sa_q[0] ^ sb_q[0] ^ br_q;
        br_next_s  = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
        res_next_s = {d_bit_s, res_q[WIDTH-1:1]};
    end

    // Next-state and datapath control for the IDLE/RUN sequencer.
    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        res_d    = res_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d    = A;
                    sb_d    = B;
                    br_d    = borrow_in;
                    res_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            RUN: begin
                sa_d  = {1'b0, sa_q[WIDTH-1:1]};
                sb_d  = {1'b0, sb_q[WIDTH-1:1]};
                br_d  = br_next_s;
                res_d = res_next_s;
                if (cnt_q == LAST_BIT) begin
                    // Publish the result including the bit computed on this edge.
                    diff_d   = res_next_s;
                    borrow_d = br_next_s;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end else begin
                    cnt_d    = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            res_q    <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            res_q    <= res_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] A;
    logic [7:0] B;
    logic       borrow_in;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow_out;

    int vectors;
    int miscompares;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .A          (A),
        .B          (B),
        .borrow_in  (borrow_in),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation from a negedge; return at the negedge where done is seen.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                         output logic [7:0] d, output logic bo, output int lat,
                         output int busy_cycles);
        A = a; B = b; borrow_in = bin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        busy_cycles = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cycles++;
            @(negedge clk);
            lat++;
        end
        d  = diff;
        bo = borrow_out;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; A = 8'd0; B = 8'd0; borrow_in = 1'b0;
        #12;
        vectors++;
        if ({busy, done, diff, borrow_out} !== 11'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got busy=%b done=%b diff=%0d bo=%b, want all 0",
                     busy, done, diff, borrow_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] d; logic bo; int lat; int bc;
        do_op(8'd0, 8'd0, 1'b0, d, bo, lat, bc);
        vectors++;
        if (lat !== 8) begin miscompares++; $display("FAIL basic_latency: got %0d want 8", lat); end
        vectors++;
        if (bc !== 8) begin miscompares++; $display("FAIL basic_busy_cycles: got %0d want 8", bc); end
        vectors++;
        if ({bo, d} !== 9'd0) begin
            miscompares++; $display("FAIL basic_result: got diff=%0d bo=%b want 0/0", d, bo);
        end
    endtask

    task automatic test_borrow_and_wide();
        logic [7:0] ta [5]  = '{8'd1, 8'd0, 8'd250, 8'd255, 8'd128};
        logic [7:0] tb_ [5] = '{8'd2, 8'd0, 8'd40,  8'd255, 8'd0};
        logic       tc [5]  = '{1'b0, 1'b1, 1'b1,   1'b1,   1'b0};
        logic [7:0] ed [5]  = '{8'd255, 8'd255, 8'd209, 8'd255, 8'd128};
        logic       eb [5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [7:0] d; logic bo; int lat; int bc;
        for (int i = 0; i < 5; i++) begin
            do_op(ta[i], tb_[i], tc[i], d, bo, lat, bc);
            vectors++;
            if (lat !== 8 || d !== ed[i] || bo !== eb[i]) begin
                miscompares++;
                $display("FAIL directed_%0d: got diff=%0d bo=%b lat=%0d want diff=%0d bo=%b lat=8",
                         i, d, bo, lat, ed[i], eb[i]);
            end
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        A = 8'd40; B = 8'd6; borrow_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            if (lat == 2) begin start = 1'b1; A = 8'd9; B = 8'd9; end
            else start = 1'b0;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        vectors++;
        if (lat !== 8 || diff !== 8'd34 || borrow_out !== 1'b0) begin
            miscompares++;
            $display("FAIL ignore_start: got diff=%0d bo=%b lat=%0d want diff=34 bo=0 lat=8",
                     diff, borrow_out, lat);
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL ignore_start_idle: got busy=%b done=%b want 0/0", busy, done);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d; logic bo; int lat; int bc;
        do_op(8'd100, 8'd1, 1'b0, d, bo, lat, bc);
        vectors++;
        if (lat !== 8 || d !== 8'd99 || bo !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_first: got diff=%0d bo=%b lat=%0d want 99/0/8", d, bo, lat);
        end
        do_op(8'd5, 8'd7, 1'b0, d, bo, lat, bc);
        vectors++;
        if (lat !== 8 || bc !== 8 || d !== 8'd254 || bo !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_second: got diff=%0d bo=%b lat=%0d busy=%0d want 254/1/8/8",
                     d, bo, lat, bc);
        end
    endtask

    task automatic test_stability();
        int lat;
        A = 8'd3; B = 8'd1; borrow_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            vectors++;
            if (diff !== 8'd254 || borrow_out !== 1'b1) begin
                miscompares++;
                $display("FAIL hold_during_busy: cycle %0d got diff=%0d bo=%b want 254/1",
                         lat, diff, borrow_out);
            end
            A = 8'($urandom); B = 8'($urandom); borrow_in = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        vectors++;
        if (lat !== 8 || diff !== 8'd2 || borrow_out !== 1'b0) begin
            miscompares++;
            $display("FAIL operand_change: got diff=%0d bo=%b lat=%0d want 2/0/8",
                     diff, borrow_out, lat);
        end
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        logic [7:0] d; logic bo; int lat; int bc; int seen;
        A = 8'd77; B = 8'd11; borrow_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, done, diff, borrow_out} !== 11'd0) begin
            miscompares++;
            $display("FAIL async_reset: got busy=%b done=%b diff=%0d bo=%b want all 0",
                     busy, done, diff, borrow_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++; $display("FAIL no_done_after_reset: got %0d active cycles want 0", seen);
        end
        do_op(8'd20, 8'd5, 1'b1, d, bo, lat, bc);
        vectors++;
        if (lat !== 8 || d !== 8'd14 || bo !== 1'b0) begin
            miscompares++;
            $display("FAIL after_reset_op: got diff=%0d bo=%b lat=%0d want 14/0/8", d, bo, lat);
        end
    endtask

    task automatic test_random();
        logic [7:0] a; logic [7:0] b; logic c; logic [8:0] exp;
        logic [7:0] d; logic bo; int lat; int bc;
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
            exp = {1'b0, a} - {1'b0, b} - {8'd0, c};
            do_op(a, b, c, d, bo, lat, bc);
            vectors++;
            if (lat !== 8 || {bo, d} !== exp) begin
                miscompares++;
                $display("FAIL random_%0d: %0d-%0d-%0d got diff=%0d bo=%b lat=%0d want diff=%0d bo=%b",
                         i, a, b, c, d, bo, lat, exp[7:0], exp[8]);
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_borrow_and_wide();
        test_ignore_start();
        test_back_to_back();
        test_stability();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
